p_ex_mem_stage: RTL and testbench
=================================

Name: p_ex_mem_stage

Overview:
- Execute stage of the RV32IM pipeline plus the EX/MEM pipeline register.
- Consumes the registered outputs of the ID/EX stage and performs ALU, branch/jump resolution and M-extension operations.
- Single-cycle ops: ALU and MUL*.
- DIV*/REM* use an iterative radix-2 divider that stalls the front of the pipe.
- Registered results feed the memory stage; the branch redirect goes combinationally to fetch.

Parameters:
- WIDTH, 32, datapath width.
- DIV_CYCLES, 32, iterations of the divider; must equal WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global advance enable; 0 freezes every register and the FSM
- i_reg_write_en, i_mem_write_en, i_mem_read_en, i_alu_src_a, i_do_branch, i_do_jump  in  1 each  control bits from ID/EX
- i_wb_sel  in  2  writeback select
- i_alu_src_b  in  2  operand B select
- i_pc, i_pc_plus_4, i_rs1_data, i_rs2_data, i_imm  in  WIDTH each  ID/EX datapath
- i_rd_addr  in  5  destination register
- i_funct3  in  3  memory access size/sign
- i_alu_op, i_branch_op  in  ALU_OP_WIDTH each  operation codes
- o_stall  out  1  hold PC, IF/ID and ID/EX (divider busy)
- o_branch_taken  out  1  combinational redirect request
- o_branch_target  out  WIDTH  combinational redirect address
- o_reg_write_en, o_mem_write_en, o_mem_read_en  out  1 each  registered control
- o_wb_sel  out  2  registered
- o_alu_result, o_store_data, o_pc_plus_4  out  WIDTH each  registered
- o_rd_addr  out  5  registered
- o_funct3  out  3  registered

Behaviour:
- Reset (async, rst=1): all registered outputs 0, divider FSM to IDLE, o_stall 0 immediately.
- Operand A: i_alu_src_a ? i_pc : i_rs1_data.
- Operand B by i_alu_src_b: 0 = rs2, 1 = imm, 2 = 4, 3 = 0.
- ALU and MUL/MULH/MULHSU/MULHU are combinational.
  - MULH* return the upper 32 bits of the 64-bit product with the correct operand signedness.
  - Shift amount is B[4:0]; SRA is arithmetic.
  - SLT is signed, SLTU is unsigned.
- Branch condition by i_branch_op: EQ, NE, LT, GE, LTU, GEU on rs1/rs2.
  - o_branch_taken = i_do_jump | (i_do_branch & cond).
- Branch target:
  - Jump: o_branch_target = alu_result with bit 0 cleared.
  - Branch: i_pc + i_imm.
  - Not taken: target is don't-care, driven as i_pc + i_imm.
- EX/MEM register, updated on each rising edge with en=1:
  - Normal load: alu/mul/div result, i_rs2_data as o_store_data, rd_addr, funct3, pc_plus_4, control bits.
  - While o_stall=1: load a bubble, i.e. all control bits 0 and datapath 0.
  - en=0: hold.
- Divider FSM states are IDLE, BUSY, DONE. All transitions require en=1.
- IDLE:
  - A DIV/DIVU/REM/REMU op present asserts o_stall=1.
  - Divisor 0 or signed overflow (0x80000000 / -1) → DONE directly.
  - Otherwise latch |dividend|, |divisor| and result sign, set count=DIV_CYCLES, → BUSY.
- BUSY:
  - o_stall=1.
  - One restoring shift-subtract step per cycle, count decrements.
  - count reaches 1 → DONE.
- DONE:
  - o_stall=0.
  - Signed-corrected quotient or remainder drives the EX/MEM result and loads at this edge.
  - → IDLE.
- Total divide occupancy in EX: DIV_CYCLES+2 cycles (34); special cases take 2 cycles.
- Divide-by-zero results:
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU remainder = dividend.
- Signed-overflow results: DIV = 0x80000000, REM = 0.
- Signs:
  - Remainder sign follows dividend.
  - Quotient is negated if the operand signs differ.
- Back-to-back divides: after DONE, the FSM returns to IDLE and accepts the next divide on the following cycle.
- Reset mid-divide: FSM to IDLE, no partial result written.
- o_branch_taken is never asserted by a divide op. A taken branch does not interact with o_stall.

Decomposition:
- ALU_OP_WIDTH, ALU op codes (including MUL..REMU) and branch op codes live in rv32i_decoder_header.vh.
- FSM state enum goes in a shared package p_pipeline_pkg.
- One sub-module, rv32i_divider: start/busy/done handshake, signed handling, special cases.
- ALU, multiplier, branch compare and EX/MEM register stay inline.

Test Plan:
- ADD, rs1=5, rs2=7, src_b=0 → next edge o_alu_result=12, o_reg_write_en=1, o_stall=0.
- BEQ, rs1=rs2=3, pc=0x100, imm=0x20 → o_branch_taken=1, o_branch_target=0x120 same cycle.
- JALR, rs1=0x203, imm=0 → target 0x202; MULH 0x80000000*2 → 0xFFFFFFFF.
- DIV -7/2 → o_stall high 33 cycles, DONE cycle result 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
- DIVU 9/0 → 0xFFFFFFFF after 2 cycles; DIV 0x80000000/-1 → 0x80000000; REM → 0.
- rst pulse at BUSY count 10 → o_stall 0 immediately, outputs 0, a subsequent DIVU 100/10 → 10.

Source files
------------

// File: rtl/p_pipeline_pkg.sv
// p_pipeline_pkg: shared ALU/branch op encodings and divider FSM states for the pipeline.
package p_pipeline_pkg;
    localparam int ALU_OP_WIDTH = 5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 5'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 5'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 5'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 5'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 5'd14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 5'd15;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 5'd16;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 5'd17;
    localparam logic [ALU_OP_WIDTH-1:0] BR_EQ      = 5'd0;
    localparam logic [ALU_OP_WIDTH-1:0] BR_NE      = 5'd1;
    localparam logic [ALU_OP_WIDTH-1:0] BR_LT      = 5'd2;
    localparam logic [ALU_OP_WIDTH-1:0] BR_GE      = 5'd3;
    localparam logic [ALU_OP_WIDTH-1:0] BR_LTU     = 5'd4;
    localparam logic [ALU_OP_WIDTH-1:0] BR_GEU     = 5'd5;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
        return op >= ALU_DIV && op <= ALU_REMU;
    endfunction
endpackage

// File: rtl/rv32i_divider.sv
// rv32i_divider: iterative radix-2 restoring divider with RISC-V signed and special-case handling.
module rv32i_divider import p_pipeline_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid,
    input  logic             is_signed,
    input  logic             is_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(DIV_CYCLES + 1);
    div_state_t state, state_nx;
    logic [WIDTH-1:0] q, r, d, a_mag, b_mag;
    logic [WIDTH:0] trial, diff;
    logic [CW-1:0] count;
    logic neg_q, neg_r, rem_sel, a_neg, b_neg, div_zero, overflow;
    assign a_neg    = is_signed & dividend[WIDTH-1];
    assign b_neg    = is_signed & divisor[WIDTH-1];
    assign a_mag    = a_neg ? -dividend : dividend;
    assign b_mag    = b_neg ? -divisor : divisor;
    assign div_zero = divisor == '0;
    assign overflow = is_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor);
    assign trial    = {r, q[WIDTH-1]};
    assign diff     = trial - {1'b0, d};
    always_comb begin
        state_nx = state == IDLE ? (valid ? ((div_zero | overflow) ? DONE : BUSY) : IDLE)
                 : state == BUSY ? (count == CW'(1) ? DONE : BUSY)
                 : IDLE;
        busy     = ~rst & ((state == IDLE & valid) | state == BUSY);
        result   = rem_sel ? (neg_r ? -r : r) : (neg_q ? -q : q);
    end
    // Special cases preload q/r with the architectural answer and skip BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            q       <= '0;
            r       <= '0;
            d       <= '0;
            count   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
        end else if (en) begin
            state <= state_nx;
            if (state == IDLE && valid) begin
                rem_sel <= is_rem;
                d       <= b_mag;
                count   <= CW'(DIV_CYCLES);
                q       <= div_zero ? '1 : overflow ? dividend : a_mag;
                r       <= div_zero ? dividend : '0;
                neg_q   <= ~div_zero & ~overflow & (a_neg ^ b_neg);
                neg_r   <= ~div_zero & ~overflow & a_neg;
            end else if (state == BUSY) begin
                q     <= {q[WIDTH-2:0], ~diff[WIDTH]};
                r     <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/p_ex_mem_stage.sv
// p_ex_mem_stage: RV32IM execute stage (ALU, multiply, divide, branch resolve) and EX/MEM register.
module p_ex_mem_stage import p_pipeline_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    i_reg_write_en,
    input  logic                    i_mem_write_en,
    input  logic                    i_mem_read_en,
    input  logic                    i_alu_src_a,
    input  logic                    i_do_branch,
    input  logic                    i_do_jump,
    input  logic [1:0]              i_wb_sel,
    input  logic [1:0]              i_alu_src_b,
    input  logic [WIDTH-1:0]        i_pc,
    input  logic [WIDTH-1:0]        i_pc_plus_4,
    input  logic [WIDTH-1:0]        i_rs1_data,
    input  logic [WIDTH-1:0]        i_rs2_data,
    input  logic [WIDTH-1:0]        i_imm,
    input  logic [4:0]              i_rd_addr,
    input  logic [2:0]              i_funct3,
    input  logic [ALU_OP_WIDTH-1:0] i_alu_op,
    input  logic [ALU_OP_WIDTH-1:0] i_branch_op,
    output logic                    o_stall,
    output logic                    o_branch_taken,
    output logic [WIDTH-1:0]        o_branch_target,
    output logic                    o_reg_write_en,
    output logic                    o_mem_write_en,
    output logic                    o_mem_read_en,
    output logic [1:0]              o_wb_sel,
    output logic [WIDTH-1:0]        o_alu_result,
    output logic [WIDTH-1:0]        o_store_data,
    output logic [WIDTH-1:0]        o_pc_plus_4,
    output logic [4:0]              o_rd_addr,
    output logic [2:0]              o_funct3
);
    localparam int SH = $clog2(WIDTH);
    logic [WIDTH-1:0] op_a, op_b, alu_result, div_result, ex_result;
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    logic [SH-1:0] shamt;
    logic is_div, div_signed, div_rem, a_signed, b_signed, eq, lt, ltu, cond;
    assign op_a  = i_alu_src_a ? i_pc : i_rs1_data;
    assign op_b  = i_alu_src_b == 2'd0 ? i_rs2_data
                 : i_alu_src_b == 2'd1 ? i_imm
                 : i_alu_src_b == 2'd2 ? WIDTH'(4) : '0;
    assign shamt = op_b[SH-1:0];
    // One shared 2W-bit multiplier; operand extension selects MUL/MULH/MULHSU/MULHU signedness.
    assign a_signed = i_alu_op == ALU_MULH | i_alu_op == ALU_MULHSU;
    assign b_signed = i_alu_op == ALU_MULH;
    assign mul_a    = {{WIDTH{a_signed & op_a[WIDTH-1]}}, op_a};
    assign mul_b    = {{WIDTH{b_signed & op_b[WIDTH-1]}}, op_b};
    assign prod     = mul_a * mul_b;
    always_comb begin
        case (i_alu_op)
            ALU_SUB:    alu_result = op_a - op_b;
            ALU_SLL:    alu_result = op_a << shamt;
            ALU_SLT:    alu_result = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_result = {{(WIDTH-1){1'b0}}, op_a < op_b};
            ALU_XOR:    alu_result = op_a ^ op_b;
            ALU_SRL:    alu_result = op_a >> shamt;
            ALU_SRA:    alu_result = $signed(op_a) >>> shamt;
            ALU_OR:     alu_result = op_a | op_b;
            ALU_AND:    alu_result = op_a & op_b;
            ALU_MUL:    alu_result = prod[WIDTH-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_result = prod[2*WIDTH-1:WIDTH];
            default:    alu_result = op_a + op_b;
        endcase
    end
    assign is_div     = is_div_op(i_alu_op);
    assign div_signed = i_alu_op == ALU_DIV | i_alu_op == ALU_REM;
    assign div_rem    = i_alu_op == ALU_REM | i_alu_op == ALU_REMU;
    assign ex_result  = is_div ? div_result : alu_result;
    rv32i_divider #(.WIDTH(WIDTH), .DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid     (is_div),
        .is_signed (div_signed),
        .is_rem    (div_rem),
        .dividend  (op_a),
        .divisor   (op_b),
        .busy      (o_stall),
        .result    (div_result)
    );
    assign eq  = i_rs1_data == i_rs2_data;
    assign lt  = $signed(i_rs1_data) < $signed(i_rs2_data);
    assign ltu = i_rs1_data < i_rs2_data;
    always_comb begin
        cond = i_branch_op == BR_EQ  ? eq
             : i_branch_op == BR_NE  ? ~eq
             : i_branch_op == BR_LT  ? lt
             : i_branch_op == BR_GE  ? ~lt
             : i_branch_op == BR_LTU ? ltu
             : i_branch_op == BR_GEU ? ~ltu : 1'b0;
        o_branch_taken  = i_do_jump | (i_do_branch & cond);
        o_branch_target = i_do_jump ? {alu_result[WIDTH-1:1], 1'b0} : i_pc + i_imm;
    end
    // A stalled cycle writes a bubble so the memory stage never sees a half-done divide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_reg_write_en <= 1'b0;
            o_mem_write_en <= 1'b0;
            o_mem_read_en  <= 1'b0;
            o_wb_sel       <= '0;
            o_alu_result   <= '0;
            o_store_data   <= '0;
            o_pc_plus_4    <= '0;
            o_rd_addr      <= '0;
            o_funct3       <= '0;
        end else if (en) begin
            o_reg_write_en <= ~o_stall & i_reg_write_en;
            o_mem_write_en <= ~o_stall & i_mem_write_en;
            o_mem_read_en  <= ~o_stall & i_mem_read_en;
            o_wb_sel       <= o_stall ? '0 : i_wb_sel;
            o_alu_result   <= o_stall ? '0 : ex_result;
            o_store_data   <= o_stall ? '0 : i_rs2_data;
            o_pc_plus_4    <= o_stall ? '0 : i_pc_plus_4;
            o_rd_addr      <= o_stall ? '0 : i_rd_addr;
            o_funct3       <= o_stall ? '0 : i_funct3;
        end
    end
endmodule

// File: tb/tb_p_ex_mem_stage.sv
// tb_p_ex_mem_stage: randomized self-checking bench for the execute stage against an arithmetic model.
module tb_p_ex_mem_stage;
    import p_pipeline_pkg::*;
    logic clk = 1'b0;
    logic rst, en;
    logic i_reg_write_en, i_mem_write_en, i_mem_read_en, i_alu_src_a, i_do_branch, i_do_jump;
    logic [1:0] i_wb_sel, i_alu_src_b;
    logic [31:0] i_pc, i_pc_plus_4, i_rs1_data, i_rs2_data, i_imm;
    logic [4:0] i_rd_addr;
    logic [2:0] i_funct3;
    logic [ALU_OP_WIDTH-1:0] i_alu_op, i_branch_op;
    logic o_stall, o_branch_taken, o_reg_write_en, o_mem_write_en, o_mem_read_en;
    logic [31:0] o_branch_target, o_alu_result, o_store_data, o_pc_plus_4;
    logic [1:0] o_wb_sel;
    logic [4:0] o_rd_addr;
    logic [2:0] o_funct3;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    p_ex_mem_stage dut (
        .clk(clk), .rst(rst), .en(en),
        .i_reg_write_en(i_reg_write_en), .i_mem_write_en(i_mem_write_en), .i_mem_read_en(i_mem_read_en),
        .i_alu_src_a(i_alu_src_a), .i_do_branch(i_do_branch), .i_do_jump(i_do_jump),
        .i_wb_sel(i_wb_sel), .i_alu_src_b(i_alu_src_b),
        .i_pc(i_pc), .i_pc_plus_4(i_pc_plus_4), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_rd_addr(i_rd_addr), .i_funct3(i_funct3), .i_alu_op(i_alu_op), .i_branch_op(i_branch_op),
        .o_stall(o_stall), .o_branch_taken(o_branch_taken), .o_branch_target(o_branch_target),
        .o_reg_write_en(o_reg_write_en), .o_mem_write_en(o_mem_write_en), .o_mem_read_en(o_mem_read_en),
        .o_wb_sel(o_wb_sel), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
        .o_pc_plus_4(o_pc_plus_4), .o_rd_addr(o_rd_addr), .o_funct3(o_funct3)
    );

    function automatic logic [31:0] ref_op(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            ALU_SUB:    return a - b;
            ALU_SLL:    return a << b[4:0];
            ALU_SLT:    return {31'b0, sa < sb};
            ALU_SLTU:   return {31'b0, ua < ub};
            ALU_XOR:    return a ^ b;
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return $signed(a) >>> b[4:0];
            ALU_OR:     return a | b;
            ALU_AND:    return a & b;
            ALU_MUL:    begin p = sa * sb; return p[31:0]; end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV:    begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            ALU_DIVU:   return b == 0 ? 32'hFFFFFFFF : a / b;
            ALU_REM:    begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            ALU_REMU:   return b == 0 ? a : a % b;
            default:    return a + b;
        endcase
    endfunction

    task automatic nop();
        i_reg_write_en = 0; i_mem_write_en = 0; i_mem_read_en = 0;
        i_alu_src_a = 0; i_do_branch = 0; i_do_jump = 0;
        i_wb_sel = 0; i_alu_src_b = 0;
        i_pc = 0; i_pc_plus_4 = 0; i_rs1_data = 0; i_rs2_data = 0; i_imm = 0;
        i_rd_addr = 0; i_funct3 = 0; i_alu_op = ALU_ADD; i_branch_op = BR_EQ;
    endtask

    task automatic drive(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
        nop();
        i_alu_op = op; i_rs1_data = a; i_rs2_data = b;
        i_reg_write_en = 1; i_rd_addr = 5'($urandom_range(31, 1)); i_funct3 = 3'($urandom);
        i_pc = $urandom & 32'hFFFFFFFC; i_pc_plus_4 = i_pc + 4;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; nop();
        #1;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", o_stall); end
        total++; if (o_reg_write_en !== 1'b0) begin bad++; $display("FAIL reset_regwr got=%b want=0", o_reg_write_en); end
        total++; if (o_alu_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", o_alu_result); end
        total++; if ({o_mem_write_en, o_mem_read_en, o_wb_sel, o_rd_addr, o_funct3} !== 12'h0) begin
            bad++; $display("FAIL reset_ctrl got=%h want=0", {o_mem_write_en, o_mem_read_en, o_wb_sel, o_rd_addr, o_funct3}); end
        total++; if ({o_store_data, o_pc_plus_4} !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {o_store_data, o_pc_plus_4}); end
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_directed();
        drive(ALU_ADD, 5, 7);
        @(posedge clk); #1;
        total++; if (o_alu_result !== 32'd12) begin bad++; $display("FAIL add_result got=%h want=c", o_alu_result); end
        total++; if (o_reg_write_en !== 1'b1) begin bad++; $display("FAIL add_regwr got=%b want=1", o_reg_write_en); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL add_stall got=%b want=0", o_stall); end
        drive(ALU_ADD, 3, 3); i_reg_write_en = 0; i_do_branch = 1; i_branch_op = BR_EQ; i_pc = 32'h100; i_imm = 32'h20;
        #1;
        total++; if (o_branch_taken !== 1'b1) begin bad++; $display("FAIL beq_taken got=%b want=1", o_branch_taken); end
        total++; if (o_branch_target !== 32'h120) begin bad++; $display("FAIL beq_target got=%h want=120", o_branch_target); end
        drive(ALU_ADD, 32'h203, 0); i_do_jump = 1; i_alu_src_b = 1; i_imm = 0;
        #1;
        total++; if (o_branch_taken !== 1'b1) begin bad++; $display("FAIL jalr_taken got=%b want=1", o_branch_taken); end
        total++; if (o_branch_target !== 32'h202) begin bad++; $display("FAIL jalr_target got=%h want=202", o_branch_target); end
        @(posedge clk); #1;
        drive(ALU_MULH, 32'h80000000, 2);
        @(posedge clk); #1;
        total++; if (o_alu_result !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulh got=%h want=ffffffff", o_alu_result); end
    endtask

    task automatic test_alu_random();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b, want;
            logic [ALU_OP_WIDTH-1:0] op;
            op = ALU_OP_WIDTH'($urandom_range(13, 0));
            drive(op, $urandom, (i % 4 == 0) ? 32'($urandom_range(40, 0)) : $urandom);
            i_alu_src_a = 1'($urandom); i_alu_src_b = 2'($urandom); i_imm = $urandom;
            i_mem_write_en = 1'($urandom); i_mem_read_en = 1'($urandom); i_wb_sel = 2'($urandom);
            a = i_alu_src_a ? i_pc : i_rs1_data;
            b = i_alu_src_b == 0 ? i_rs2_data : i_alu_src_b == 1 ? i_imm : i_alu_src_b == 2 ? 32'd4 : 32'd0;
            want = ref_op(op, a, b);
            @(posedge clk); #1;
            total++; if (o_alu_result !== want) begin bad++; $display("FAIL alu op=%0d a=%h b=%h got=%h want=%h", op, a, b, o_alu_result, want); end
            total++; if ({o_store_data, o_pc_plus_4, o_rd_addr, o_funct3, o_wb_sel, o_mem_write_en, o_mem_read_en, o_reg_write_en}
                         !== {i_rs2_data, i_pc_plus_4, i_rd_addr, i_funct3, i_wb_sel, i_mem_write_en, i_mem_read_en, 1'b1}) begin
                bad++; $display("FAIL passthru got=%h/%h/%h want=%h/%h/%h", o_store_data, o_pc_plus_4, o_rd_addr, i_rs2_data, i_pc_plus_4, i_rd_addr); end
        end
    endtask

    task automatic test_branch_random();
        for (int i = 0; i < 60; i++) begin
            logic c, want_taken;
            logic [31:0] want_tgt;
            drive(ALU_ADD, $urandom, 0);
            i_rs2_data = (i % 3 == 0) ? i_rs1_data : $urandom;
            i_branch_op = ALU_OP_WIDTH'($urandom_range(5, 0));
            i_do_branch = 1'($urandom); i_do_jump = (i % 5 == 0);
            i_alu_src_a = 1'($urandom); i_alu_src_b = 1; i_imm = $urandom;
            case (i_branch_op)
                BR_EQ:   c = i_rs1_data == i_rs2_data;
                BR_NE:   c = i_rs1_data != i_rs2_data;
                BR_LT:   c = $signed(i_rs1_data) < $signed(i_rs2_data);
                BR_GE:   c = $signed(i_rs1_data) >= $signed(i_rs2_data);
                BR_LTU:  c = i_rs1_data < i_rs2_data;
                default: c = i_rs1_data >= i_rs2_data;
            endcase
            want_taken = i_do_jump | (i_do_branch & c);
            want_tgt = i_do_jump ? (((i_alu_src_a ? i_pc : i_rs1_data) + i_imm) & ~32'h1) : i_pc + i_imm;
            #1;
            total++; if (o_branch_taken !== want_taken) begin bad++; $display("FAIL br_taken op=%0d got=%b want=%b", i_branch_op, o_branch_taken, want_taken); end
            total++; if (o_branch_target !== want_tgt) begin bad++; $display("FAIL br_target got=%h want=%h", o_branch_target, want_tgt); end
            total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL br_stall got=%b want=0", o_stall); end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_div(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] want;
        int edges, want_edges;
        want = ref_op(op, a, b);
        want_edges = (b == 0 || ((op == ALU_DIV || op == ALU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33;
        drive(op, a, b);
        #1;
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL div_start_stall got=%b want=1", o_stall); end
        edges = 0;
        while (o_stall === 1'b1 && edges < 100) begin
            @(posedge clk); #1; edges++;
            if (edges == 1) begin
                total++; if (o_reg_write_en !== 1'b0) begin bad++; $display("FAIL div_bubble got=%b want=0", o_reg_write_en); end
            end
        end
        total++; if (edges !== want_edges) begin bad++; $display("FAIL div_latency op=%0d got=%0d want=%0d", op, edges, want_edges); end
        @(posedge clk); #1;
        total++; if (o_alu_result !== want) begin bad++; $display("FAIL div_result op=%0d a=%h b=%h got=%h want=%h", op, a, b, o_alu_result, want); end
        total++; if (o_reg_write_en !== 1'b1) begin bad++; $display("FAIL div_regwr got=%b want=1", o_reg_write_en); end
    endtask

    task automatic test_div();
        run_div(ALU_DIV, 32'hFFFFFFF9, 2);
        run_div(ALU_REM, 32'hFFFFFFF9, 2);
        run_div(ALU_DIVU, 9, 0);
        run_div(ALU_REM, 9, 0);
        run_div(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_div(ALU_REM, 32'h80000000, 32'hFFFFFFFF);
        run_div(ALU_DIVU, 32'h80000000, 32'hFFFFFFFF);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            run_div(ALU_OP_WIDTH'($urandom_range(17, 14)), $urandom, (i == 3) ? 32'h0 : $urandom >> $urandom_range(28, 0));
    endtask

    task automatic test_enable();
        logic [31:0] held;
        drive(ALU_XOR, 32'h1234, 32'hFF00);
        @(posedge clk); #1;
        held = 32'h1234 ^ 32'hFF00;
        drive(ALU_ADD, 1, 1); en = 0;
        @(posedge clk); #1;
        total++; if (o_alu_result !== held) begin bad++; $display("FAIL en_hold got=%h want=%h", o_alu_result, held); end
        en = 1;
        @(posedge clk); #1;
        total++; if (o_alu_result !== 32'd2) begin bad++; $display("FAIL en_resume got=%h want=2", o_alu_result); end
    endtask

    task automatic test_reset_mid_div();
        drive(ALU_DIV, 1000, 3);
        repeat (23) @(posedge clk);
        #1;
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL middiv_busy got=%b want=1", o_stall); end
        rst = 1;
        #1;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL middiv_stall got=%b want=0", o_stall); end
        total++; if ({o_alu_result, o_reg_write_en} !== 33'h0) begin bad++; $display("FAIL middiv_out got=%h want=0", {o_alu_result, o_reg_write_en}); end
        nop();
        @(posedge clk); #1; rst = 0;
        total++; if (o_alu_result !== 32'h0) begin bad++; $display("FAIL middiv_nopartial got=%h want=0", o_alu_result); end
        run_div(ALU_DIVU, 100, 10);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_alu_random();
        test_branch_random();
        test_div();
        test_back_to_back();
        test_enable();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
